// File: rtl/if_stage.sv
// Purpose : fetch stage with the IF/ID pipeline register. Holds the PC, picks the next PC, registers the fetched word.
// Latency : the word at pcF=A reaches instrD one cycle later. A taken branch or jump costs exactly one bubble.
// Backpr. : stallF holds the PC and stallD holds IF/ID. Stall beats flush and redirect; no valid/ready handshake.
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   stallF, stallD, flushD        hazard-unit controls
//   pcsrcD, branch_targetD        taken branch resolved in decode, with its target
//   jumpD                         J/JAL in decode; the target is built from instrD/pcplus4D
//   imem_addr, imem_rdata         instruction memory port (combinational read)
//   pcF                           current fetch PC
//   instrD, pcplus4D, validD      IF/ID register contents
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcD,
  input  logic [31:0] branch_targetD,
  input  logic        jumpD,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  logic [31:0] pcplus4F;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] pc_next;
  logic        redirect;

  // Sequential PC. The add wraps modulo 2^32 on purpose.
  assign pcplus4F      = pcF + 32'd4;
  assign jump_target   = {pcplus4D[31:28], instrD[25:0], 2'b00};
  assign branch_target = {branch_targetD[31:2], 2'b00};

  // A stalled decode instruction must not steer fetch. Its branch or jump
  // decision is stale until decode moves on.
  assign redirect = (jumpD | pcsrcD) & ~stallD;

  always_comb begin
    pc_next = pcplus4F;
    if (jumpD & ~stallD)
      pc_next = jump_target;
    else if (pcsrcD & ~stallD)
      pc_next = branch_target;
  end

  // The address comes only from the PC register. No input reaches it combinationally.
  assign imem_addr = pcF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pcF <= RESET_PC;
    else if (!stallF)
      pcF <= pc_next;
  end

  // IF/ID register. A redirect squashes the wrong-path word fetched in the same
  // cycle, because the pipeline has no delay slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrD   <= NOP_WORD;
      pcplus4D <= 32'd0;
      validD   <= 1'b0;
    end else if (stallD) begin
      instrD   <= instrD;
      pcplus4D <= pcplus4D;
      validD   <= validD;
    end else if (flushD || redirect) begin
      instrD   <= NOP_WORD;
      pcplus4D <= 32'd0;
      validD   <= 1'b0;
    end else begin
      instrD   <= imem_rdata;
      pcplus4D <= pcplus4F;
      validD   <= 1'b1;
    end
  end

endmodule
